// File: rtl/adc_pkg.sv
// Shared types for the scanning ADC averager: FSM state encoding and the
// channel-index width derivation used by every port that carries a channel.
package adc_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SAMPLE = 3'd1,
    DIVIDE = 3'd2,
    ACCUM  = 3'd3,
    OUT    = 3'd4
  } state_t;

  // A single-channel build still needs a 1-bit channel field.
  function automatic int ch_width(input int channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

endpackage

// File: rtl/adc_seq_div.sv
// Restoring divider: one quotient bit per cycle, MSB first, fixed WIDTH-cycle
// latency after start. The upper dividend half must be below the divisor for
// the quotient to fit in WIDTH bits; the caller saturates when it does not.
module adc_seq_div #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [2*WIDTH-1:0]   dividend,
  input  logic [WIDTH-1:0]     divisor,
  output logic                 done,
  output logic [WIDTH-1:0]     quotient
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] dvd_lo;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH:0]   trial;
  logic             fits;

  assign trial = {rem, dvd_lo[WIDTH-1]};
  assign fits  = (trial >= {1'b0, divisor});
  // done flags the cycle in which the last quotient bit is being produced.
  assign done  = (cnt == CNT_W'(1));

  // Load on start, then shift-and-subtract while the down-counter runs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem      <= '0;
      dvd_lo   <= '0;
      cnt      <= '0;
      quotient <= '0;
    end else if (start) begin
      rem      <= dividend[2*WIDTH-1:WIDTH];
      dvd_lo   <= dividend[WIDTH-1:0];
      cnt      <= CNT_W'(WIDTH);
      quotient <= '0;
    end else if (cnt != '0) begin
      rem      <= fits ? WIDTH'(trial - {1'b0, divisor}) : trial[WIDTH-1:0];
      dvd_lo   <= dvd_lo << 1;
      quotient <= (quotient << 1) | WIDTH'(fits);
      cnt      <= cnt - CNT_W'(1);
    end
  end

endmodule

// File: rtl/adc_scan_avg.sv
// Scanning ADC result averager. Each result is the truncated mean of
// 2^AVG_LOG2 ratiometric codes floor(Vin*(2^WIDTH-1)/Vref), one channel at a
// time, either once or continuously round-robin.
//
// state  | meaning
// IDLE   | waiting for start
// SAMPLE | latch Vin/Vref of the current channel, kick the divider
// DIVIDE | divider running (WIDTH cycles)
// ACCUM  | add code to accumulator, loop for more samples or finish
// OUT    | present result, hold until out_ready
module adc_scan_avg import adc_pkg::*; #(
  parameter  int WIDTH    = 8,
  parameter  int CHANNELS = 4,
  parameter  int AVG_LOG2 = 2,
  localparam int CH_W     = ch_width(CHANNELS)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        mode,
  input  logic [CH_W-1:0]             ch_sel,
  input  logic [CHANNELS*WIDTH-1:0]   Vin,
  input  logic [WIDTH-1:0]            Vref,
  output logic [WIDTH-1:0]            digital_out,
  output logic [CH_W-1:0]             out_ch,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        busy,
  output logic                        vref_err
);

  localparam int ACC_W  = WIDTH + AVG_LOG2;
  localparam int SAMP_W = AVG_LOG2 + 1;
  localparam logic [SAMP_W-1:0] NSAMP = SAMP_W'(1) << AVG_LOG2;

  state_t             state;
  logic [CH_W-1:0]    cur_ch;
  logic [CH_W-1:0]    ch_start;
  logic [CH_W-1:0]    ch_next;
  logic [WIDTH-1:0]   vin_cur;
  logic [WIDTH-1:0]   vin_lat;
  logic [WIDTH-1:0]   vref_lat;
  logic [2*WIDTH-1:0] dividend;
  logic [WIDTH-1:0]   div_q;
  logic               div_done;
  logic               sat;
  logic [WIDTH-1:0]   code;
  logic [ACC_W-1:0]   acc;
  logic [SAMP_W-1:0]  samp_left;
  logic               err_acc;

  assign ch_start = (int'(ch_sel) < CHANNELS) ? ch_sel : '0;
  assign ch_next  = (int'(cur_ch) == CHANNELS - 1) ? '0 : cur_ch + CH_W'(1);
  assign vin_cur  = Vin[int'(cur_ch)*WIDTH +: WIDTH];
  // Vin*(2^WIDTH-1) without a multiplier.
  assign dividend = {vin_cur, {WIDTH{1'b0}}} - {{WIDTH{1'b0}}, vin_cur};
  // Out-of-range input and a dead reference both pin the code at full scale.
  assign sat      = (vin_lat >= vref_lat) || (vref_lat == '0);
  assign code     = sat ? '1 : div_q;

  adc_seq_div #(.WIDTH(WIDTH)) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (state == SAMPLE),
    .dividend (dividend),
    .divisor  (Vref),
    .done     (div_done),
    .quotient (div_q)
  );

  // Sequencing FSM with registered outputs; out_valid rises one cycle after
  // entering OUT so the presented mean always includes the final sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      busy        <= 1'b0;
      cur_ch      <= '0;
      vin_lat     <= '0;
      vref_lat    <= '0;
      acc         <= '0;
      samp_left   <= '0;
      err_acc     <= 1'b0;
      digital_out <= '0;
      out_ch      <= '0;
      out_valid   <= 1'b0;
      vref_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            cur_ch    <= ch_start;
            acc       <= '0;
            samp_left <= NSAMP;
            err_acc   <= 1'b0;
            busy      <= 1'b1;
            state     <= SAMPLE;
          end
        end
        SAMPLE: begin
          vin_lat  <= vin_cur;
          vref_lat <= Vref;
          if (Vref == '0) err_acc <= 1'b1;
          state    <= DIVIDE;
        end
        DIVIDE: begin
          if (div_done) state <= ACCUM;
        end
        ACCUM: begin
          acc       <= acc + ACC_W'(code);
          samp_left <= samp_left - SAMP_W'(1);
          state     <= (samp_left == SAMP_W'(1)) ? OUT : SAMPLE;
        end
        OUT: begin
          if (!out_valid) begin
            digital_out <= WIDTH'(acc >> AVG_LOG2);
            out_ch      <= cur_ch;
            out_valid   <= 1'b1;
            vref_err    <= err_acc;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            vref_err  <= 1'b0;
            if (mode) begin
              cur_ch    <= ch_next;
              acc       <= '0;
              samp_left <= NSAMP;
              err_acc   <= 1'b0;
              state     <= SAMPLE;
            end else begin
              busy  <= 1'b0;
              state <= IDLE;
            end
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adc_scan_avg.sv
// Bench for adc_scan_avg: one instance without averaging, one averaging four
// samples. Expected results are queued when a conversion is launched and
// popped when the instance presents out_valid.
module tb_adc_scan_avg;
  localparam int WIDTH    = 8;
  localparam int CHANNELS = 4;
  localparam int CH_W     = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [CHANNELS*WIDTH-1:0] vin;
  logic [WIDTH-1:0]          vref;

  logic            start_a, mode_a, ready_a, valid_a, busy_a, err_a;
  logic [CH_W-1:0] ch_sel_a, och_a;
  logic [WIDTH-1:0] dout_a;
  logic            start_b, mode_b, ready_b, valid_b, busy_b, err_b;
  logic [CH_W-1:0] ch_sel_b, och_b;
  logic [WIDTH-1:0] dout_b;

  adc_scan_avg #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .AVG_LOG2(0)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .mode(mode_a), .ch_sel(ch_sel_a),
    .Vin(vin), .Vref(vref), .digital_out(dout_a), .out_ch(och_a),
    .out_valid(valid_a), .out_ready(ready_a), .busy(busy_a), .vref_err(err_a)
  );

  adc_scan_avg #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .AVG_LOG2(2)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .mode(mode_b), .ch_sel(ch_sel_b),
    .Vin(vin), .Vref(vref), .digital_out(dout_b), .out_ch(och_b),
    .out_valid(valid_b), .out_ready(ready_b), .busy(busy_b), .vref_err(err_b)
  );

  typedef struct packed {
    logic [7:0] code;
    logic [1:0] ch;
    logic       err;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int checks = 0;
  int errors = 0;

  function automatic logic [7:0] model_code(input int v, input int r);
    if (r == 0 || v >= r) return 8'd255;
    return 8'((v * 255) / r);
  endfunction

  task automatic wait_valid_a(input int budget, output int n);
    n = 0;
    while (valid_a !== 1'b1 && n < budget) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (valid_a !== 1'b1) begin
      errors++;
      $display("FAIL wait_valid_a: out_valid=%b after %0d cycles, expected 1", valid_a, n);
    end
  endtask

  task automatic wait_valid_b(input int budget, output int n);
    n = 0;
    while (valid_b !== 1'b1 && n < budget) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (valid_b !== 1'b1) begin
      errors++;
      $display("FAIL wait_valid_b: out_valid=%b after %0d cycles, expected 1", valid_b, n);
    end
  endtask

  task automatic test_reset;
    #22;
    checks++;
    if ({dout_a, och_a, valid_a, busy_a, err_a} !== '0) begin
      errors++;
      $display("FAIL reset_a: dout=%0d ch=%0d valid=%b busy=%b err=%b expected all 0",
               dout_a, och_a, valid_a, busy_a, err_a);
    end
    checks++;
    if ({dout_b, och_b, valid_b, busy_b, err_b} !== '0) begin
      errors++;
      $display("FAIL reset_b: dout=%0d ch=%0d valid=%b busy=%b err=%b expected all 0",
               dout_b, och_b, valid_b, busy_b, err_b);
    end
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
  endtask

  // Single-shot conversion on the non-averaging instance.
  task automatic conv_a(input int ch, input int v, input int r);
    exp_t e;
    int n;
    for (int k = 0; k < CHANNELS; k++) vin[k*WIDTH +: WIDTH] = 8'($urandom_range(0, 255));
    vin[ch*WIDTH +: WIDTH] = 8'(v);
    vref = 8'(r);
    e.code = model_code(v, r);
    e.ch   = 2'(ch);
    e.err  = (r == 0);
    q_a.push_back(e);
    ch_sel_a = 2'(ch); mode_a = 1'b0; ready_a = 1'b1; start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    wait_valid_a(200, n);
    checks++;
    if (n !== 11) begin
      errors++;
      $display("FAIL latency_a: got %0d cycles expected 11 (vin=%0d vref=%0d)", n, v, r);
    end
    e = q_a.pop_front();
    checks++;
    if (dout_a !== e.code) begin
      errors++;
      $display("FAIL code_a: vin=%0d vref=%0d got %0d expected %0d", v, r, dout_a, e.code);
    end
    checks++;
    if (och_a !== e.ch) begin
      errors++;
      $display("FAIL out_ch_a: got %0d expected %0d", och_a, e.ch);
    end
    checks++;
    if (err_a !== e.err) begin
      errors++;
      $display("FAIL vref_err_a: vref=%0d got %b expected %b", r, err_a, e.err);
    end
    @(posedge clk); #1;
    checks++;
    if (valid_a !== 1'b0 || busy_a !== 1'b0) begin
      errors++;
      $display("FAIL release_a: valid=%b busy=%b expected 0 0", valid_a, busy_a);
    end
  endtask

  task automatic test_first;
    conv_a(1, 9, 18);
  endtask

  task automatic test_sweep;
    for (int v = 6; v <= 18; v++) conv_a(v % CHANNELS, v, 18);
    conv_a(2, 20, 10);
  endtask

  task automatic test_vref_zero;
    conv_a(3, 77, 0);
    conv_a(0, 0, 0);
    conv_a(0, 5, 18);
  endtask

  // Four-sample average; even samples use v0, odd use v1; the first sample
  // sees reference r0, the rest r1.
  task automatic avg_b(input int ch, input int v0, input int v1, input int r0, input int r1);
    exp_t e;
    int n, sum, s;
    logic err;
    sum = 0; err = 1'b0;
    for (int k = 0; k < 4; k++) begin
      sum += model_code((k % 2 == 1) ? v1 : v0, (k == 0) ? r0 : r1);
      if (((k == 0) ? r0 : r1) == 0) err = 1'b1;
    end
    e.code = 8'(sum / 4); e.ch = 2'(ch); e.err = err;
    q_b.push_back(e);
    vin[ch*WIDTH +: WIDTH] = 8'(v0);
    vref = 8'(r0);
    s = 0;
    ch_sel_b = 2'(ch); mode_b = 1'b0; ready_b = 1'b1; start_b = 1'b1;
    @(posedge clk); #1 start_b = 1'b0;
    n = 0;
    while (valid_b !== 1'b1 && n < 400) begin
      @(posedge clk); #1; n++;
      if (n % 10 == 1) begin
        s++;
        vin[ch*WIDTH +: WIDTH] = 8'((s % 2 == 1) ? v1 : v0);
        vref = 8'(r1);
      end
    end
    checks++;
    if (valid_b !== 1'b1 || n !== 41) begin
      errors++;
      $display("FAIL latency_b: valid=%b after %0d cycles expected 1 after 41", valid_b, n);
    end
    e = q_b.pop_front();
    checks++;
    if (dout_b !== e.code || och_b !== e.ch || err_b !== e.err) begin
      errors++;
      $display("FAIL avg_b: got code=%0d ch=%0d err=%b expected code=%0d ch=%0d err=%b",
               dout_b, och_b, err_b, e.code, e.ch, e.err);
    end
    @(posedge clk); #1;
    checks++;
    if (valid_b !== 1'b0 || busy_b !== 1'b0) begin
      errors++;
      $display("FAIL release_b: valid=%b busy=%b expected 0 0", valid_b, busy_b);
    end
  endtask

  task automatic test_average;
    avg_b(2, 6, 18, 18, 18);
    avg_b(0, 18, 18, 0, 18);
    avg_b(1, 9, 9, 18, 18);
  endtask

  task automatic test_scan;
    exp_t e;
    int n;
    vref = 8'd50;
    for (int k = 0; k < CHANNELS; k++) vin[k*WIDTH +: WIDTH] = 8'(10 * (k + 1));
    for (int k = 0; k < 3; k++) begin
      e.ch = 2'((3 + k) % CHANNELS);
      e.code = model_code(10 * (int'(e.ch) + 1), 50);
      e.err = 1'b0;
      q_a.push_back(e);
    end
    ch_sel_a = 2'd3; mode_a = 1'b1; ready_a = 1'b0; start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    for (int r = 0; r < 3; r++) begin
      wait_valid_a(200, n);
      checks++;
      if (n !== 11) begin
        errors++;
        $display("FAIL scan_latency: result %0d got %0d cycles expected 11", r, n);
      end
      e = q_a.pop_front();
      checks++;
      if (dout_a !== e.code || och_a !== e.ch || err_a !== e.err) begin
        errors++;
        $display("FAIL scan_result: got code=%0d ch=%0d err=%b expected code=%0d ch=%0d err=%b",
                 dout_a, och_a, err_a, e.code, e.ch, e.err);
      end
      if (r == 0) begin
        for (int i = 0; i < 5; i++) begin
          if (i == 1) begin start_a = 1'b1; ch_sel_a = 2'd1; end
          if (i == 2) start_a = 1'b0;
          @(posedge clk); #1;
          checks++;
          if (valid_a !== 1'b1 || dout_a !== e.code || och_a !== e.ch || err_a !== 1'b0) begin
            errors++;
            $display("FAIL scan_hold: cycle %0d valid=%b code=%0d ch=%0d expected 1 %0d %0d",
                     i, valid_a, dout_a, och_a, e.code, e.ch);
          end
        end
        ready_a = 1'b1;
      end
      if (r == 2) mode_a = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (valid_a !== 1'b0 || busy_a !== (r != 2)) begin
        errors++;
        $display("FAIL scan_handshake: result %0d valid=%b busy=%b expected 0 %b",
                 r, valid_a, busy_a, (r != 2));
      end
    end
    repeat (15) @(posedge clk);
    #1;
    checks++;
    if (busy_a !== 1'b0 || valid_a !== 1'b0) begin
      errors++;
      $display("FAIL scan_stop: busy=%b valid=%b expected 0 0", busy_a, valid_a);
    end
  endtask

  task automatic test_reset_mid;
    int n;
    vref = 8'd18;
    vin[1*WIDTH +: WIDTH] = 8'd9;
    ch_sel_b = 2'd1; mode_b = 1'b0; ready_b = 1'b0; start_b = 1'b1;
    @(posedge clk); #1 start_b = 1'b0;
    wait_valid_b(200, n);
    vin[2*WIDTH +: WIDTH] = 8'd12;
    ch_sel_a = 2'd2; mode_a = 1'b0; ready_a = 1'b1; start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    repeat (4) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checks++;
    if ({dout_a, och_a, valid_a, busy_a, err_a} !== '0) begin
      errors++;
      $display("FAIL reset_mid_a: dout=%0d ch=%0d valid=%b busy=%b expected all 0",
               dout_a, och_a, valid_a, busy_a);
    end
    checks++;
    if ({dout_b, och_b, valid_b, busy_b, err_b} !== '0) begin
      errors++;
      $display("FAIL reset_mid_b: dout=%0d ch=%0d valid=%b busy=%b expected all 0",
               dout_b, och_b, valid_b, busy_b);
    end
    ready_b = 1'b1;
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    conv_a(2, 12, 18);
  endtask

  initial begin
    rst = 1'b1;
    vin = '0; vref = '0;
    start_a = 1'b0; mode_a = 1'b0; ready_a = 1'b1; ch_sel_a = '0;
    start_b = 1'b0; mode_b = 1'b0; ready_b = 1'b1; ch_sel_b = '0;
    test_reset;
    test_first;
    test_sweep;
    test_vref_zero;
    test_average;
    test_scan;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/adc_scan_avg.md
ADC_SCAN_AVG -- requirements
Module: adc_scan_avg

Interface
REQ-001 Parameter WIDTH, default 8, sets the sample and code width in bits.
REQ-002 Parameter CHANNELS, default 4, sets the number of analog input channels (>=1).
REQ-003 Parameter AVG_LOG2, default 2, averages 2^AVG_LOG2 samples per channel result.
REQ-004 Port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-005 Port rst, input, 1, reset, asynchronous and active-high.
REQ-006 Port start, input, 1, conversion request, sampled only in IDLE.
REQ-007 Port mode, input, 1: 0 = single channel; 1 = continuous scan.
REQ-008 Port ch_sel, input, CH_W = max(1,clog2(CHANNELS)), first channel converted.
REQ-009 Port Vin, input, CHANNELS*WIDTH, packed channel voltages; channel k is bits [k*WIDTH +: WIDTH].
REQ-010 Port Vref, input, WIDTH, reference voltage.
REQ-011 Port digital_out, output, WIDTH, averaged code.
REQ-012 Port out_ch, output, CH_W, channel of digital_out.
REQ-013 Port out_valid, output, 1, result available.
REQ-014 Port out_ready, input, 1, consumer accepts the result.
REQ-015 Port busy, output, 1, high in every state except IDLE.
REQ-016 Port vref_err, output, 1, high with out_valid when any averaged sample saw Vref==0.

Function
REQ-017 States SHALL be IDLE, SAMPLE, DIVIDE, ACCUM, OUT.
REQ-018 IDLE -> SAMPLE on start==1: latch ch_sel as the current channel, clear the accumulator and sample counter.
REQ-019 SAMPLE (1 cycle) SHALL latch Vin[current channel] and Vref.
REQ-020 DIVIDE SHALL last exactly WIDTH cycles, computing q = floor(Vin*(2^WIDTH-1)/Vref) by restoring division, one quotient bit per cycle, MSB first.
REQ-021 If latched Vin>=Vref or Vref==0, q SHALL be 2^WIDTH-1; latency SHALL be unchanged. Vref==0 SHALL set the sticky error bit.
REQ-022 ACCUM (1 cycle) SHALL add q into a WIDTH+AVG_LOG2-bit accumulator with no overflow; then go to SAMPLE if fewer than 2^AVG_LOG2 samples are taken, else to OUT.
REQ-023 On entering OUT: digital_out = accumulator >> AVG_LOG2 (truncating); out_ch = current channel; out_valid = 1.
REQ-024 digital_out, out_ch, out_valid and vref_err SHALL hold stable until out_valid && out_ready on a rising edge.
REQ-025 On handshake with mode==0: go to IDLE, clear out_valid.
REQ-026 On handshake with mode==1: advance channel, wrapping CHANNELS-1 -> 0, and go to SAMPLE; out_valid is cleared.
REQ-027 mode is sampled only at the OUT handshake; dropping it mid-scan SHALL end the scan after the current channel.
REQ-028 start outside IDLE SHALL be ignored.
REQ-029 Latency SHALL be (WIDTH+2)*2^AVG_LOG2 + 1 cycles from the start-accept edge to out_valid high.
REQ-030 ch_sel >= CHANNELS SHALL be treated as channel 0.

Reset
REQ-031 rst SHALL force IDLE immediately, including mid-conversion or mid-handshake.
REQ-032 Reset values: digital_out=0, out_ch=0, out_valid=0, busy=0, vref_err=0; accumulator, counters and divider registers = 0.

Structure
REQ-033 State encodings and the CH_W derivation SHALL live in the shared package adc_pkg.
REQ-034 The restoring divider SHALL be the sub-module adc_seq_div: start/done; WIDTH-bit divisor; 2*WIDTH-bit dividend; fixed WIDTH-cycle latency.

Verification (WIDTH=8, CHANNELS=4)
REQ-035 AVG_LOG2=0, mode=0, ch_sel=1, Vin ch1=9, Vref=18, start -> out_valid after 11 cycles, digital_out=127, out_ch=1.
REQ-036 AVG_LOG2=0, Vref=18, sweep Vin=6..18 -> codes 85 at Vin=6 and 255 at Vin=18, monotonic; Vin=20, Vref=10 -> 255, vref_err=0.
REQ-037 Vref=0, any Vin -> digital_out=255 and vref_err=1.
REQ-038 AVG_LOG2=2, Vin toggling 6/18 per sample, Vref=18 -> digital_out=(85+255+85+255)>>2=170, 41 cycles latency.
REQ-039 mode=1, ch_sel=3, out_ready held low 5 cycles -> outputs stable; after acceptance channels 0,1,... follow, and mode dropped ends the scan.
REQ-040 rst pulsed mid-DIVIDE -> all outputs 0 asynchronously; next start gives the correct full-latency result.
